// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
// Data-memory request/acknowledge bus between the memory stage and the
// data memory.
//   req   : request, held high until ack
//   we    : 1 = write, 0 = read
//   addr  : word-aligned address
//   wdata : lane-replicated store data
//   be    : byte enables
//   ack   : memory completes the request this cycle
//   rdata : read word, valid together with ack
// master = memory stage side, slave = memory side.
interface mem_access_stage_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory stage downstream of execute. It passes non-memory results straight
// to writeback, performs loads and stores over a req/ack data-memory bus
// (byte lanes, sign/zero extension, alignment checks) and stalls upstream
// while an access is outstanding. All writeback and fault outputs are
// registered.
//
// Optional feature: define DMEM_TIMEOUT_EN to abort an access that sees no
// ack for TIMEOUT_CYCLES BUSY cycles (reported as a fault).
//
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_en                valid instruction presented this cycle
//   load_i, store_i     instruction is a load / store
//   funct3_i            size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   alu_result_i        effective address or writeback value
//   store_data_i        store source data
//   rd_i                destination register
//   write_reg_file_i    execute-stage regfile write request
//   stall_o             hold upstream inputs stable
//   dmem                data-memory bus (master side)
//   wb_valid_o, wb_we_o, wb_rd_o, wb_data_o   writeback outputs
//   fault_o, fault_addr_o                     one-cycle fault pulse + address
//
// States:
//   IDLE | accepting instructions; passthrough, fault or launch
//   BUSY | request outstanding, waiting for ack
//   DONE | writeback of the completed access, upstream released
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic                        load_i,
    input  logic                        store_i,
    input  logic [2:0]                  funct3_i,
    input  logic [31:0]                 alu_result_i,
    input  logic [31:0]                 store_data_i,
    input  logic [4:0]                  rd_i,
    input  logic                        write_reg_file_i,
    output logic                        stall_o,
    mem_access_stage_if.master          dmem,
    output logic                        wb_valid_o,
    output logic                        wb_we_o,
    output logic [4:0]                  wb_rd_o,
    output logic [31:0]                 wb_data_o,
    output logic                        fault_o,
    output logic [31:0]                 fault_addr_o
);

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nx;
    logic        req_q, req_nx;
    logic        we_q, we_nx;
    logic [31:0] addr_q, addr_nx;
    logic [31:0] wdata_q, wdata_nx;
    logic [3:0]  be_q, be_nx;
    logic [4:0]  rd_q, rd_nx;
    logic [2:0]  f3_q, f3_nx;
    logic        wb_valid_q, wb_valid_nx;
    logic        wb_we_q, wb_we_nx;
    logic [4:0]  wb_rd_q, wb_rd_nx;
    logic [31:0] wb_data_q, wb_data_nx;
    logic        fault_q, fault_nx;
    logic [31:0] fault_addr_q, fault_addr_nx;
`ifdef DMEM_TIMEOUT_EN
    logic [31:0] tmo_cnt, tmo_nx;
`endif

    logic        memop, bad, f3_ok, launch;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] rd_shift;
    logic [15:0] rd_half;
    logic [31:0] ld_data;

    assign memop = i_en & (load_i | store_i);
    assign f3_ok = (funct3_i == 3'b000) | (funct3_i == 3'b001) | (funct3_i == 3'b010) |
                   (funct3_i == 3'b100) | (funct3_i == 3'b101);
    // funct3[2] set on a legal code means BU/HU, which have no store form.
    assign bad   = (load_i & store_i) | !f3_ok | (store_i & funct3_i[2]) |
                   ((funct3_i[1:0] == 2'b01) & alu_result_i[0]) |
                   ((funct3_i == 3'b010) & (alu_result_i[1:0] != 2'b00));
    assign launch  = (state == IDLE) & memop & !bad;
    assign stall_o = launch | (state == BUSY);

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = store_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                st_be    = 4'b0001 << alu_result_i[1:0];
                st_wdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                st_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane extraction uses the byte offset captured at launch.
    assign rd_shift = dmem.rdata >> {addr_q[1:0], 3'b000};
    assign rd_half  = addr_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];

    always_comb begin
        ld_data = dmem.rdata;
        case (f3_q)
            3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  ld_data = {24'h0, rd_shift[7:0]};
            3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  ld_data = {16'h0, rd_half};
            default: ld_data = dmem.rdata;
        endcase
    end

    always_comb begin
        state_nx      = state;
        req_nx        = req_q;
        we_nx         = we_q;
        addr_nx       = addr_q;
        wdata_nx      = wdata_q;
        be_nx         = be_q;
        rd_nx         = rd_q;
        f3_nx         = f3_q;
        wb_valid_nx   = 1'b0;
        wb_we_nx      = 1'b0;
        wb_rd_nx      = wb_rd_q;
        wb_data_nx    = wb_data_q;
        fault_nx      = 1'b0;
        fault_addr_nx = fault_addr_q;
`ifdef DMEM_TIMEOUT_EN
        tmo_nx        = tmo_cnt;
`endif
        case (state)
            IDLE: begin
                if (i_en && !memop) begin
                    wb_valid_nx = 1'b1;
                    wb_we_nx    = write_reg_file_i & (rd_i != 5'd0);
                    wb_rd_nx    = rd_i;
                    wb_data_nx  = alu_result_i;
                end else if (memop && bad) begin
                    wb_valid_nx   = 1'b1;
                    wb_rd_nx      = rd_i;
                    wb_data_nx    = alu_result_i;
                    fault_nx      = 1'b1;
                    fault_addr_nx = alu_result_i;
                end else if (launch) begin
                    state_nx = BUSY;
                    req_nx   = 1'b1;
                    we_nx    = store_i;
                    addr_nx  = alu_result_i;
                    be_nx    = store_i ? st_be : 4'b1111;
                    wdata_nx = store_i ? st_wdata : 32'h0;
                    rd_nx    = rd_i;
                    f3_nx    = funct3_i;
`ifdef DMEM_TIMEOUT_EN
                    tmo_nx   = 32'd0;
`endif
                end
            end
            BUSY: begin
                if (dmem.ack) begin
                    state_nx    = DONE;
                    req_nx      = 1'b0;
                    wb_valid_nx = 1'b1;
                    wb_rd_nx    = rd_q;
                    if (!we_q) begin
                        wb_data_nx = ld_data;
                        wb_we_nx   = (rd_q != 5'd0);
                    end
                end
`ifdef DMEM_TIMEOUT_EN
                else if (tmo_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_nx      = DONE;
                    req_nx        = 1'b0;
                    wb_valid_nx   = 1'b1;
                    wb_rd_nx      = rd_q;
                    fault_nx      = 1'b1;
                    fault_addr_nx = addr_q;
                end else begin
                    tmo_nx = tmo_cnt + 32'd1;
                end
`endif
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            req_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            be_q         <= 4'h0;
            rd_q         <= 5'd0;
            f3_q         <= 3'd0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= 32'h0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
`ifdef DMEM_TIMEOUT_EN
            tmo_cnt      <= 32'd0;
`endif
        end else begin
            state        <= state_nx;
            req_q        <= req_nx;
            we_q         <= we_nx;
            addr_q       <= addr_nx;
            wdata_q      <= wdata_nx;
            be_q         <= be_nx;
            rd_q         <= rd_nx;
            f3_q         <= f3_nx;
            wb_valid_q   <= wb_valid_nx;
            wb_we_q      <= wb_we_nx;
            wb_rd_q      <= wb_rd_nx;
            wb_data_q    <= wb_data_nx;
            fault_q      <= fault_nx;
            fault_addr_q <= fault_addr_nx;
`ifdef DMEM_TIMEOUT_EN
            tmo_cnt      <= tmo_nx;
`endif
        end
    end

    assign dmem.req     = req_q;
    assign dmem.we      = we_q;
    assign dmem.addr    = {addr_q[31:2], 2'b00};
    assign dmem.wdata   = wdata_q;
    assign dmem.be      = be_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_we_o      = wb_we_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign fault_o      = fault_q;
    assign fault_addr_o = fault_addr_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage directly downstream of `execute`.
- Consumes the ALU result (effective address or writeback value), the store data, the destination register and the write-enable.
- Performs loads and stores over a req/ack data-memory port, with byte lanes, load sign/zero extension and alignment checks.
- Produces registered writeback outputs and stalls upstream while a memory access is outstanding.

Parameters:
TIMEOUT_CYCLES, 64, BUSY cycles without ack before abort (only with DMEM_TIMEOUT_EN)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous active-high reset
i_en  in  1  valid instruction presented this cycle
load_i  in  1  instruction is a load
store_i  in  1  instruction is a store
funct3_i  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
alu_result_i  in  32  effective address (mem op) or writeback value
store_data_i  in  32  rs2 value for stores
rd_i  in  5  destination register
write_reg_file_i  in  1  execute-stage regfile write request
stall_o  out  1  hold upstream inputs stable
dmem_req_o  out  1  memory request, held until ack
dmem_we_o  out  1  1 = write
dmem_addr_o  out  32  word address {addr[31:2],2'b00}
dmem_wdata_o  out  32  lane-replicated store data
dmem_be_o  out  4  byte enables
dmem_ack_i  in  1  memory completes the request this cycle
dmem_rdata_i  in  32  read word, valid with ack
wb_valid_o  out  1  writeback outputs valid this cycle
wb_we_o  out  1  regfile write enable
wb_rd_o  out  5  writeback register
wb_data_o  out  32  writeback value
fault_o  out  1  one-cycle pulse: misaligned, illegal op or timeout
fault_addr_o  out  32  faulting byte address

Behaviour:
- Reset: i_rst sampled on the rising i_clk edge.
  - Next cycle: state=IDLE; all outputs 0 (including dmem_req_o, wb_valid_o, fault_o, fault_addr_o).
  - Reset while BUSY aborts the access; no writeback is produced; a later dmem_ack_i is ignored in IDLE.
- States: IDLE, BUSY, DONE.
- memop = i_en & (load_i | store_i).
- bad = one of:
  - load_i & store_i;
  - funct3 not in {000,001,010,100,101};
  - store with funct3 100/101;
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0.
- launch = IDLE & memop & !bad.
- stall_o (combinational) = launch | (state==BUSY).
- IDLE, i_en & !memop: one-cycle passthrough.
  - Next cycle: wb_valid_o=1, wb_data_o=alu_result_i, wb_rd_o=rd_i, wb_we_o = write_reg_file_i & (rd_i!=0).
- IDLE, memop & bad: no request issued, no stall.
  - Next cycle: wb_valid_o=1, wb_we_o=0, fault_o=1, fault_addr_o=alu_result_i.
- IDLE, launch: register address, we, be, wdata, rd and funct3, then go to BUSY.
  - dmem_req_o=1 from the next cycle.
  - Request fields stay stable until ack.
- BUSY, dmem_ack_i=1: dmem_req_o=0 next cycle; go to DONE.
  - Load: wb_data_o = extracted read data; wb_we_o = (rd!=0).
  - Store: wb_we_o=0.
- BUSY, no ack: remain in BUSY.
- DONE: wb_valid_o=1 for exactly one cycle; stall_o=0.
  - Upstream advances at the end of this cycle.
  - The inputs presented during DONE are the completed instruction and are ignored.
  - Next state is IDLE.
- Minimum memop latency: presentation to stall release is 3 cycles (launch, BUSY with ack, DONE).
- wb_valid_o = 0 in every cycle that is not a passthrough, fault or DONE cycle.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{store_data[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{store_data[15:0]}}.
  - SW: be = 1111; wdata = store_data.
- Load lanes: be = 1111 for all loads.
  - LB/LBU: byte selected by addr[1:0], sign- or zero-extended.
  - LH/LHU: halfword selected by addr[1], sign- or zero-extended.
  - LW: full word.
- Load to rd=0: the access is performed; wb_we_o=0.

Optional Feature:
- DMEM_TIMEOUT_EN defined:
  - A counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES, dmem_req_o drops next cycle and the stage goes to DONE with wb_we_o=0, fault_o=1, fault_addr_o = byte address.
  - Ack in the same cycle as expiry wins (normal completion).
- DMEM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely.

Test Plan:
- Store byte: SB, addr 0x1003, data 0x000000AB, ack after 2 BUSY cycles -> dmem_addr_o=0x1000, be=1000, wdata=0xABABABAB, dmem_we_o=1; DONE with wb_we_o=0; stall_o high exactly 3 cycles.
- Loads: rdata 0x8000F0FF at addr 0x2002 -> LH gives 0xFFFF8000, LHU 0x00008000, LB at 0x2000 gives 0xFFFFFFFF, LBU at 0x2001 gives 0x000000F0; wb_valid_o 1 cycle each.
- Misaligned: LW at 0x3001 -> dmem_req_o never asserted, stall_o=0, next cycle fault_o=1, fault_addr_o=0x3001, wb_we_o=0.
- Passthrough: ADD result 0x12345678, rd=5, then rd=0 -> wb_data_o=0x12345678, wb_we_o=1 then 0, one cycle after each.
- Reset mid-op: i_rst asserted in the 2nd BUSY cycle of an LW -> IDLE, dmem_req_o=0 next cycle; ack on the following cycle produces no wb_valid_o.
- Timeout (DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4), no ack -> fault_o pulses, dmem_req_o drops, wb_we_o=0; without the macro, req stays high for 100 cycles.
